// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: processor opcode and
// register codes, and the sequencer state encoding.
package instr_sequencer_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_MOV  = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_OUT  = 2'b11;

  localparam logic [2:0] REG_A = 3'b000;
  localparam logic [2:0] REG_B = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_HOLD,
    S_CAPTURE,
    S_DONE
  } seq_state_t;

  // Only the output opcode needs special handling; all others pass through.
  function automatic logic is_out_op(input logic [1:0] op);
    return op == OP_OUT;
  endfunction

endpackage

// File: rtl/instr_sequencer_prog_mem.sv
// Program store: one {instruction, load data} word per entry.
// Synchronous write, asynchronous read, contents survive reset.
module prog_mem #(
  parameter int PROG_DEPTH = 16,
  parameter int INSTR_W    = 8,
  parameter int DATA_W     = 8,
  localparam int AW        = $clog2(PROG_DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] winstr,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rinstr,
  output logic [DATA_W-1:0]  rdata
);

  logic [INSTR_W+DATA_W-1:0] mem [PROG_DEPTH];

  // Write port: store instruction and its load value together.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= {winstr, wdata};
  end

  assign {rinstr, rdata} = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer: issues stored instructions to the processor one at a
// time, holds each for a fixed gap and captures OUT values for output ops.
module instr_sequencer #(
  parameter int PROG_DEPTH = 16,
  parameter int INSTR_W    = 8,
  parameter int DATA_W     = 8,
  parameter int ISSUE_GAP  = 2,
  localparam int AW        = $clog2(PROG_DEPTH),
  localparam int LEN_W     = AW + 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               prog_we,
  input  logic [AW-1:0]      prog_addr,
  input  logic [INSTR_W-1:0] prog_instr,
  input  logic [DATA_W-1:0]  prog_data,
  input  logic [LEN_W-1:0]   prog_len,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [INSTR_W-1:0] instr,
  output logic [DATA_W-1:0]  ld_ext,
  output logic               proc_en,
  input  logic [DATA_W-1:0]  proc_out,
  output logic [DATA_W-1:0]  result,
  output logic               result_valid,
  output logic [7:0]         result_count
);
  import instr_sequencer_pkg::*;

  localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(PROG_DEPTH);

  seq_state_t         state, state_nx;
  logic [AW-1:0]      pc;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   start_len;
  logic [GW-1:0]      gap_cnt;
  logic               gap_last;
  logic               last_pc;
  logic               out_op;
  logic               mem_we;
  logic [INSTR_W-1:0] mem_instr;
  logic [DATA_W-1:0]  mem_data;

  // Writes are only accepted while idle so a running program cannot change.
  assign mem_we    = prog_we && (state == S_IDLE);
  assign start_len = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
  assign gap_last  = (gap_cnt == GW'(ISSUE_GAP - 1));
  assign last_pc   = ({1'b0, pc} == (len - 1'b1));
  assign out_op    = is_out_op(instr[INSTR_W-1 -: 2]);

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign proc_en = (state == S_ISSUE);

  prog_mem #(
    .PROG_DEPTH (PROG_DEPTH),
    .INSTR_W    (INSTR_W),
    .DATA_W     (DATA_W)
  ) u_prog_mem (
    .clk    (CLK),
    .we     (mem_we),
    .waddr  (prog_addr),
    .winstr (prog_instr),
    .wdata  (prog_data),
    .raddr  (pc),
    .rinstr (mem_instr),
    .rdata  (mem_data)
  );

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Next-state logic; the "next instruction" decision is folded into the
  // HOLD and CAPTURE exits so it costs no cycle of its own.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (start) state_nx = (start_len == '0) ? S_DONE : S_FETCH;
      S_FETCH:   state_nx = S_ISSUE;
      S_ISSUE:   state_nx = S_HOLD;
      S_HOLD:    if (gap_last) state_nx = out_op ? S_CAPTURE : (last_pc ? S_DONE : S_FETCH);
      S_CAPTURE: state_nx = last_pc ? S_DONE : S_FETCH;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Program counter, run length and hold-gap counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc      <= '0;
      len     <= '0;
      gap_cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          len <= start_len;
          pc  <= '0;
        end
        S_ISSUE: gap_cnt <= '0;
        S_HOLD: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_last && !out_op && !last_pc) pc <= pc + 1'b1;
        end
        S_CAPTURE: if (!last_pc) pc <= pc + 1'b1;
        default: ;
      endcase
    end
  end

  // Instruction/load outputs and result capture; instr and ld_ext keep
  // their last values after the run ends.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      instr        <= '0;
      ld_ext       <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      result_count <= '0;
    end else begin
      result_valid <= (state == S_CAPTURE);
      if (state == S_IDLE && start) result_count <= '0;
      if (state == S_FETCH) begin
        instr  <= mem_instr;
        ld_ext <= mem_data;
      end
      if (state == S_CAPTURE) begin
        result       <= proc_out;
        result_count <= result_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a driver loads programs and starts
// runs, a reference model predicts the issue stream, results and run
// timing, and a negedge monitor compares what the DUT presents.
module tb_instr_sequencer;

  logic       CLK;
  logic       RST;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_instr;
  logic [7:0] prog_data;
  logic [4:0] prog_len;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] instr;
  logic [7:0] ld_ext;
  logic       proc_en;
  logic [7:0] proc_out;
  logic [7:0] result;
  logic       result_valid;
  logic [7:0] result_count;

  instr_sequencer #(
    .PROG_DEPTH (16),
    .INSTR_W    (8),
    .DATA_W     (8),
    .ISSUE_GAP  (2)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_instr   (prog_instr),
    .prog_data    (prog_data),
    .prog_len     (prog_len),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .instr        (instr),
    .ld_ext       (ld_ext),
    .proc_en      (proc_en),
    .proc_out     (proc_out),
    .result       (result),
    .result_valid (result_valid),
    .result_count (result_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Processor stand-in: registers A..H, executes on each issue strobe.
  logic [7:0] pregs [8];
  logic       proc_clr;
  always @(posedge CLK) begin
    if (proc_clr) begin
      for (int k = 0; k < 8; k++) pregs[k] <= 8'd0;
      proc_out <= 8'd0;
    end else if (proc_en) begin
      case (instr[7:6])
        2'b00:   pregs[instr[5:3]] <= ld_ext;
        2'b01:   pregs[instr[5:3]] <= pregs[instr[2:0]];
        2'b10:   pregs[instr[5:3]] <= pregs[instr[5:3]] + pregs[instr[2:0]];
        default: proc_out <= pregs[instr[5:3]];
      endcase
    end
  end

  typedef struct {
    int n;
    int n_out;
    int lat;
  } run_t;

  logic [15:0] exp_iq [$];
  logic [7:0]  exp_rq [$];
  run_t        run_q  [$];

  logic [7:0] sh_i [16];
  logic [7:0] sh_d [16];

  int checks = 0;
  int errors = 0;
  int runs_launched = 0;
  int runs_done = 0;
  bit end_req = 0;
  bit end_ack = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference model: run the stored program through the processor's
  // semantics with a fresh register file.
  task automatic build_ref(input int len);
    logic [7:0] r [8];
    logic [7:0] ins;
    int n, nout, cyc;
    for (int k = 0; k < 8; k++) r[k] = 8'd0;
    n = (len > 16) ? 16 : len;
    nout = 0;
    cyc = 0;
    for (int i = 0; i < n; i++) begin
      ins = sh_i[i];
      exp_iq.push_back({ins, sh_d[i]});
      case (ins[7:6])
        2'b00:   r[ins[5:3]] = sh_d[i];
        2'b01:   r[ins[5:3]] = r[ins[2:0]];
        2'b10:   r[ins[5:3]] = r[ins[5:3]] + r[ins[2:0]];
        default: begin
          exp_rq.push_back(r[ins[5:3]]);
          nout++;
        end
      endcase
      cyc += (ins[7:6] == 2'b11) ? 5 : 4;
    end
    run_q.push_back('{n: n, n_out: nout, lat: cyc + 1});
  endtask

  // Monitor: all comparisons happen here, on the falling edge.
  int lat = 0;
  int pen_cnt = 0;
  int res_idx = 0;
  bit in_run = 0;
  bit in_reset = 0;
  always @(negedge CLK) begin : mon
    logic [15:0] ei;
    logic [7:0]  er;
    run_t        rr;
    if (!RST) begin
      if (!in_reset) begin
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_proc_en", proc_en, 0);
        chk("rst_instr", instr, 0);
        chk("rst_ld_ext", ld_ext, 0);
        chk("rst_result", result, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_result_count", result_count, 0);
        in_reset = 1;
      end
      exp_iq.delete();
      exp_rq.delete();
      run_q.delete();
      in_run = 0;
    end else begin
      in_reset = 0;
      if (in_run) lat++;
      if (proc_en) begin
        pen_cnt++;
        if (exp_iq.size() == 0) chk("unexpected_issue", 1, 0);
        else begin
          ei = exp_iq.pop_front();
          chk("issue_instr", instr, ei[15:8]);
          chk("issue_ld_ext", ld_ext, ei[7:0]);
        end
      end
      if (result_valid) begin
        res_idx++;
        if (exp_rq.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          er = exp_rq.pop_front();
          chk("result", result, er);
        end
        chk("result_count_step", result_count, res_idx);
      end
      if (done) begin
        if (!in_run || run_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          rr = run_q.pop_front();
          chk("done_latency", lat, rr.lat);
          chk("proc_en_count", pen_cnt, rr.n);
          chk("result_count_end", result_count, rr.n_out);
          runs_done++;
        end
        in_run = 0;
      end else if (in_run && lat > 120) begin
        chk("run_timeout", 1, 0);
        if (run_q.size() != 0) void'(run_q.pop_front());
        in_run = 0;
        runs_done++;
      end
      if (start && !busy && !in_run) begin
        in_run  = 1;
        lat     = 0;
        pen_cnt = 0;
        res_idx = 0;
      end
      if (end_req && !end_ack) begin
        chk("leftover_issues", exp_iq.size(), 0);
        chk("leftover_results", exp_rq.size(), 0);
        chk("runs_completed", runs_done, runs_launched);
        end_ack = 1;
      end
    end
  end

  task automatic write_entry(input int a, input logic [7:0] ins, input logic [7:0] dat);
    prog_we = 1'b1;
    prog_addr = 4'(a);
    prog_instr = ins;
    prog_data = dat;
    @(posedge CLK);
    #1;
    prog_we = 1'b0;
    sh_i[a] = ins;
    sh_d[a] = dat;
  endtask

  // Start a run; optionally write one entry in the same cycle.
  task automatic launch(input int len, input bit we, input int a,
                        input logic [7:0] ins, input logic [7:0] dat);
    prog_len = 5'(len);
    start = 1'b1;
    proc_clr = 1'b1;
    if (we) begin
      prog_we = 1'b1;
      prog_addr = 4'(a);
      prog_instr = ins;
      prog_data = dat;
      sh_i[a] = ins;
      sh_d[a] = dat;
    end
    build_ref(len);
    runs_launched++;
    @(posedge CLK);
    #1;
    start = 1'b0;
    proc_clr = 1'b0;
    prog_we = 1'b0;
  endtask

  task automatic wait_run();
    int t;
    t = 0;
    while (runs_done != runs_launched && t < 400) begin
      @(posedge CLK);
      #1;
      t++;
    end
    if (runs_done != runs_launched) begin
      $display("FAIL wait_run got %0d runs expected %0d", runs_done, runs_launched);
      $fatal(1, "run did not complete");
    end
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic wait_issue();
    int t;
    t = 0;
    while (!proc_en && t < 50) begin
      @(posedge CLK);
      #1;
      t++;
    end
    if (!proc_en) begin
      $display("FAIL wait_issue got 0 expected 1");
      $fatal(1, "no issue strobe");
    end
  endtask

  logic [7:0] demo [8] = '{8'h00, 8'hC7, 8'h48, 8'hC8, 8'h81, 8'hC0, 8'h81, 8'hC0};

  initial begin
    RST = 1'b1;
    prog_we = 1'b0;
    prog_addr = '0;
    prog_instr = '0;
    prog_data = '0;
    prog_len = '0;
    start = 1'b0;
    proc_clr = 1'b1;
    #2 RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
    proc_clr = 1'b0;

    // Demonstration program, ld_ext = 15: results 15, 15, 30, 45.
    for (int i = 0; i < 8; i++) write_entry(i, demo[i], 8'd15);
    launch(8, 0, 0, 8'd0, 8'd0);
    wait_run();

    // Empty run.
    launch(0, 0, 0, 8'd0, 8'd0);
    wait_run();

    // Reset in the middle of HOLD, then rerun from the top.
    launch(8, 0, 0, 8'd0, 8'd0);
    wait_issue();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    runs_launched--;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    launch(8, 0, 0, 8'd0, 8'd0);
    wait_run();

    // Clamp: fill the whole store and ask for more than it holds.
    for (int i = 0; i < 16; i++) write_entry(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    launch(31, 0, 0, 8'd0, 8'd0);
    wait_run();

    // Write and start while busy are ignored.
    launch(16, 0, 0, 8'd0, 8'd0);
    wait_issue();
    @(posedge CLK);
    #1;
    prog_we = 1'b1;
    prog_addr = 4'd0;
    prog_instr = 8'hC0;
    prog_data = 8'hAA;
    start = 1'b1;
    prog_len = 5'd3;
    @(posedge CLK);
    #1;
    prog_we = 1'b0;
    start = 1'b0;
    wait_run();
    launch(1, 0, 0, 8'd0, 8'd0);
    wait_run();

    // Write and start in the same idle cycle.
    write_entry(0, 8'h00, 8'd9);
    launch(1, 1, 0, 8'hC7, 8'd21);
    wait_run();
    launch(2, 1, 1, 8'hC0, 8'd3);
    wait_run();

    // Randomized programs and lengths.
    for (int r = 0; r < 12; r++) begin
      for (int w = 0; w < 6; w++)
        write_entry($urandom_range(0, 15), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      launch($urandom_range(0, 20), 0, 0, 8'd0, 8'd0);
      wait_run();
    end

    end_req = 1'b1;
    for (int t = 0; t < 10 && !end_ack; t++) @(posedge CLK);
    #1;
    if (!end_ack) begin
      $display("FAIL end_handshake got 0 expected 1");
      $fatal(1, "monitor did not finish");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Program sequencer that drives the processor's instruction and external-load inputs from a small on-chip program store, replacing hand-stepped stimulus.
- Program is loaded through a write port, then issued one instruction at a time on `start`.
- Each issue is marked by an `proc_en` strobe, and `instr` is held for a fixed gap.
- For output-opcode instructions (`instr[7:6]` = 11), the processor's `OUT` value is captured and presented as a result stream.
- Sits between the host/testbench and the processor's instruction port.

Parameters:
- PROG_DEPTH, 16, number of program entries (power of 2).
- INSTR_W, 8, instruction width (`instr[7:6]` opcode, `[5:3]` dest/sel, `[2:0]` src).
- DATA_W, 8, width of `ld_ext` and processor `OUT`.
- ISSUE_GAP, 2, idle cycles `instr` is held after the issue strobe (min 1).

Ports:
- CLK, input, 1, system clock, rising edge.
- RST, input, 1, asynchronous active-low reset.
- prog_we, input, 1, program write enable (honoured only when busy=0).
- prog_addr, input, log2(PROG_DEPTH), program write address.
- prog_instr, input, INSTR_W, instruction to store.
- prog_data, input, DATA_W, `ld_ext` value stored with the instruction.
- prog_len, input, log2(PROG_DEPTH)+1, number of entries to run; sampled on start.
- start, input, 1, begin run (honoured only in IDLE).
- busy, output, 1, high from the cycle after start acceptance until DONE exits.
- done, output, 1, one-cycle pulse at end of run.
- instr, output, INSTR_W, instruction to processor.
- ld_ext, output, DATA_W, external load value to processor.
- proc_en, output, 1, one-cycle issue strobe to processor.
- proc_out, input, DATA_W, processor `OUT`.
- result, output, DATA_W, captured output value.
- result_valid, output, 1, one-cycle pulse when `result` is updated.
- result_count, output, 8, results captured this run; wraps mod 256.

Behaviour:
- Reset (RST=0, async):
  - state=IDLE, pc=0, len=0.
  - instr, ld_ext, result, result_count = 0.
  - busy, done, proc_en, result_valid = 0.
  - Program memory is not cleared.
- IDLE:
  - prog_we writes {prog_instr, prog_data} to prog_addr on the edge.
  - start=1: latch len=min(prog_len, PROG_DEPTH), pc=0, result_count=0.
  - Go to DONE if len=0, else go to FETCH.
- FETCH (1 cycle):
  - instr<=mem_instr[pc], ld_ext<=mem_data[pc].
  - Go to ISSUE.
- ISSUE (1 cycle): proc_en=1. Go to HOLD.
- HOLD (ISSUE_GAP cycles, counter): proc_en=0; instr and ld_ext are stable.
  - On the last cycle, go to CAPTURE if instr[7:6]=11, else go to NEXT.
- CAPTURE (1 cycle):
  - result<=proc_out; result_valid pulses in the following cycle.
  - result_count<=result_count+1.
  - Go to NEXT.
- NEXT (combined into the CAPTURE/HOLD exit edge, no extra cycle):
  - If pc=len-1, go to DONE; else pc<=pc+1 and go to FETCH.
- DONE (1 cycle): done=1, busy=0 at exit. Go to IDLE.
  - instr and ld_ext keep their last values.
- Cycles per instruction, with ISSUE_GAP=2: 4 for non-output instructions, 5 for output instructions.
- busy=1 in FETCH, ISSUE, HOLD, CAPTURE and DONE.
- prog_we and start while busy are ignored, with no side effect.
- start and prog_we in the same IDLE cycle:
  - Both take effect.
  - FETCH occurs a later cycle, so it reads the new contents.
- prog_len > PROG_DEPTH is clamped.
- RST low mid-run: immediate IDLE, all outputs to reset values, no done pulse.
- Opcode decode is limited to the 11 check; other opcodes pass through unmodified.

Decomposition:
- Shared package:
  - OP_LOAD=2'b00, OP_MOV=2'b01, OP_ADD=2'b10, OP_OUT=2'b11.
  - Register codes REG_A=3'b000, REG_B=3'b001.
  - Sequencer state encoding (IDLE, FETCH, ISSUE, HOLD, CAPTURE, DONE).
- One sub-module, `prog_mem`:
  - PROG_DEPTH × (INSTR_W+DATA_W) array.
  - Synchronous write, asynchronous read, no reset.

Test Plan:
- Reset:
  - Stimulus: assert RST low mid-HOLD.
  - Response: busy=0, proc_en=0, instr=0, result_count=0 immediately; no done pulse. A rerun after release starts at pc=0.
- Full program against a behavioural processor model, ld_ext=15:
  - Program: 00000000, 11000111, 01001000, 11001000, 10000001, 11000000, 10000001, 11000000.
  - Response: results 15, 15, 30, 45, each with a result_valid pulse; result_count=4; done after 8×4+4 = 36 cycles from FETCH; exactly 8 proc_en pulses.
- Empty run:
  - Stimulus: prog_len=0 with start.
  - Response: done pulses in the next cycle; proc_en is never asserted.
- Clamp:
  - Stimulus: prog_len=31, PROG_DEPTH=16.
  - Response: exactly 16 proc_en pulses; pc never exceeds 15.
- Busy protection:
  - Stimulus: prog_we to addr 0 with instr=11000000, plus start, both during a run.
  - Response: the run is unaffected; the memory read back in the next run shows the old value.
- Write/start same cycle:
  - Stimulus: prog_we to addr 0 with 11000111 together with start, prog_len=1.
  - Response: instr=11000111 at ISSUE; one result captured.
